// File: rtl/systolic_collect_bottom_out_if.sv
// rtl/systolic_collect_bottom_out_if.sv - start/data/result handshake bundle for the bottom-edge deskew collector
interface systolic_collect_bottom_out_if #(
  parameter int MAC_WIDTH = 4,
  parameter int ACC_SIZE  = 16
);
  logic                                        instr;
  logic [ACC_SIZE*MAC_WIDTH-1:0]               data_in;
  logic                                        matrix_ready;
  logic [ACC_SIZE*MAC_WIDTH*MAC_WIDTH-1:0]     matrix_out;
  logic                                        matrix_valid;
  logic                                        busy;

  modport master (
    output instr, data_in, matrix_ready,
    input  matrix_out, matrix_valid, busy
  );

  modport slave (
    input  instr, data_in, matrix_ready,
    output matrix_out, matrix_valid, busy
  );
endinterface

// File: rtl/systolic_collect_bottom_out.sv
// rtl/systolic_collect_bottom_out.sv - deskews the bottom-edge result wavefront into a row-major matrix
// Optional sticky start-overrun flag: define SYSTOLIC_COLLECT_OVERRUN_EN.
module systolic_collect_bottom_out #(
  parameter int MAC_WIDTH = 4,
  parameter int ACC_SIZE  = 16
) (
  input  logic clock,
  input  logic reset,
  systolic_collect_bottom_out_if.slave bus
`ifdef SYSTOLIC_COLLECT_OVERRUN_EN
  ,
  output logic overrun
`endif
);

  localparam int LAST_K = 2 * MAC_WIDTH - 2;
  localparam int KW     = $clog2(2 * MAC_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                                    state_q, state_d;
  logic [KW-1:0]                             k_q, k_d;
  logic                                      capture_en;
  logic [ACC_SIZE*MAC_WIDTH*MAC_WIDTH-1:0]   matrix_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // The edge that samples instr in IDLE is itself capture k=0, so IDLE and
  // COLLECT share the same capture/advance path.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    capture_en = 1'b0;
    case (state_q)
      IDLE:    capture_en = bus.instr;
      COLLECT: capture_en = 1'b1;
      DONE:    if (bus.matrix_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture_en) begin
      if (k_q == KW'(LAST_K)) begin
        state_d = DONE;
        k_d     = '0;
      end else begin
        state_d = COLLECT;
        k_d     = k_q + KW'(1);
      end
    end
  end

  // Element (r,c) sits on the anti-diagonal r+c of the wavefront.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      matrix_q <= '0;
    end else if (capture_en) begin
      for (int r = 0; r < MAC_WIDTH; r++) begin
        for (int c = 0; c < MAC_WIDTH; c++) begin
          if (k_q == KW'(r + c)) begin
            matrix_q[(r*MAC_WIDTH+c)*ACC_SIZE +: ACC_SIZE] <= bus.data_in[c*ACC_SIZE +: ACC_SIZE];
          end
        end
      end
    end
  end

  assign bus.matrix_out   = matrix_q;
  assign bus.matrix_valid = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);

`ifdef SYSTOLIC_COLLECT_OVERRUN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (bus.instr && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_collect_bottom_out.sv
// tb/tb_systolic_collect_bottom_out.sv - directed self-checking bench for systolic_collect_bottom_out
module tb_systolic_collect_bottom_out;

  localparam int MW  = 4;
  localparam int ACC = 16;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  systolic_collect_bottom_out_if #(.MAC_WIDTH(MW), .ACC_SIZE(ACC)) bus ();

`ifdef SYSTOLIC_COLLECT_OVERRUN_EN
  logic overrun;
  systolic_collect_bottom_out #(.MAC_WIDTH(MW), .ACC_SIZE(ACC)) dut (
    .clock(clock), .reset(reset), .bus(bus), .overrun(overrun)
  );
`else
  systolic_collect_bottom_out #(.MAC_WIDTH(MW), .ACC_SIZE(ACC)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected element values: mode 0 = 16r+c+1, mode 1 = 0x100+4r+c,
  // mode 2 = 0xFFFF only at (0,3) and (3,0).
  function automatic logic [15:0] expect_elem(input int mode, input int r, input int c);
    case (mode)
      0:       return 16'(16 * r + c + 1);
      1:       return 16'(256 + r * 4 + c);
      default: return ((r == 0 && c == 3) || (r == 3 && c == 0)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic logic [MW*ACC-1:0] wave(input int mode, input int k);
    logic [MW*ACC-1:0] v;
    int r;
    v = '0;
    for (int c = 0; c < MW; c++) begin
      r = k - c;
      if (mode == 2) begin
        v[c*ACC +: ACC] = (k == 3 && r >= 0 && r < MW) ? expect_elem(2, r, c) : 16'h0000;
      end else if (r >= 0 && r < MW) begin
        v[c*ACC +: ACC] = expect_elem(mode, r, c);
      end else begin
        v[c*ACC +: ACC] = 16'hDEAD;
      end
    end
    return v;
  endfunction

  function automatic logic [15:0] elem(input int r, input int c);
    return bus.matrix_out[(r*MW+c)*ACC +: ACC];
  endfunction

  task automatic check_matrix(input string tag, input int mode);
    for (int r = 0; r < MW; r++) begin
      for (int c = 0; c < MW; c++) begin
        check($sformatf("%s_e%0d%0d", tag, r, c), 32'(elem(r, c)), 32'(expect_elem(mode, r, c)));
      end
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One full collect: 7 capture edges, optional extra instr pulse at edge extra_k.
  task automatic run(input string tag, input int mode, input int extra_k);
    for (int k = 0; k <= 2*MW-2; k++) begin
      bus.instr   = (k == 0) || (k == extra_k);
      bus.data_in = wave(mode, k);
      tick();
      bus.instr = 1'b0;
      check($sformatf("%s_busy_k%0d", tag, k), 32'(bus.busy), 32'd1);
      check($sformatf("%s_valid_k%0d", tag, k), 32'(bus.matrix_valid), (k == 2*MW-2) ? 32'd1 : 32'd0);
    end
    bus.data_in = '0;
    check_matrix(tag, mode);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.instr        = 1'b0;
    bus.data_in      = '0;
    bus.matrix_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.matrix_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_matrix", 32'(|bus.matrix_out), 32'd0);
    reset = 1'b1;
    tick();

    // Basic collect, then hold with ready low and single-cycle handshake
    run("basic", 0, -1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.matrix_valid), 32'd1);
      check("hold_e00", 32'(elem(0, 0)), 32'h0001);
      check("hold_e33", 32'(elem(3, 3)), 32'h0034);
    end
    bus.matrix_ready = 1'b1;
    tick();
    bus.matrix_ready = 1'b0;
    check("hs_valid", 32'(bus.matrix_valid), 32'd0);
    check("hs_busy", 32'(bus.busy), 32'd0);
    check("hs_keep_e33", 32'(elem(3, 3)), 32'h0034);
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Ignored starts during COLLECT and DONE
    run("ignore", 0, 3);
    bus.instr = 1'b1;
    tick();
    check("done_instr_valid", 32'(bus.matrix_valid), 32'd1);
    check("done_instr_e30", 32'(elem(3, 0)), 32'h0031);
    bus.matrix_ready = 1'b1;
    tick();
    bus.instr = 1'b0;
    bus.matrix_ready = 1'b0;
    check("hs_instr_busy", 32'(bus.busy), 32'd0);
    tick();
    check("no_restart_busy", 32'(bus.busy), 32'd0);
`ifdef SYSTOLIC_COLLECT_OVERRUN_EN
    check("overrun_set", 32'(overrun), 32'd1);
`endif

    // Back-to-back with ready tied high: starts at E0 and E8
    bus.matrix_ready = 1'b1;
    run("b2b_a", 0, -1);
    tick();
    check("b2b_gap_valid", 32'(bus.matrix_valid), 32'd0);
    check("b2b_gap_busy", 32'(bus.busy), 32'd0);
    run("b2b_b", 1, -1);
    tick();
    bus.matrix_ready = 1'b0;
    check("b2b_end_valid", 32'(bus.matrix_valid), 32'd0);

    // Asynchronous reset between E3 and E4
    for (int k = 0; k <= 3; k++) begin
      bus.instr   = (k == 0);
      bus.data_in = wave(0, k);
      tick();
    end
    bus.instr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.matrix_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_matrix", 32'(|bus.matrix_out), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("arst_idle_busy", 32'(bus.busy), 32'd0);
    run("post_rst", 1, -1);
    bus.matrix_ready = 1'b1;
    tick();
    bus.matrix_ready = 1'b0;
`ifdef SYSTOLIC_COLLECT_OVERRUN_EN
    check("overrun_cleared", 32'(overrun), 32'd0);
`endif

    // Wavefront boundary: only (0,3) and (3,0) set at k=3
    run("edge", 2, -1);
    bus.matrix_ready = 1'b1;
    tick();
    bus.matrix_ready = 1'b0;
    check("edge_hs_valid", 32'(bus.matrix_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
